// File: rtl/data_memory_unit_if.sv
// Request/response bus of the MEM-stage data memory: command in, ready/done/result out.
interface data_memory_unit_if #(
    parameter int unsigned ADDRESS_LENGTH = 8
);
    logic                      req;
    logic                      write_enable;
    logic [1:0]                size;
    logic                      unsigned_load;
    logic [ADDRESS_LENGTH+1:0] address;
    logic [31:0]               write_data;
    logic                      ready;
    logic                      done;
    logic [31:0]               read_data;
    logic                      misaligned;

    modport master (
        output req, write_enable, size, unsigned_load, address, write_data,
        input  ready, done, read_data, misaligned
    );

    modport slave (
        input  req, write_enable, size, unsigned_load, address, write_data,
        output ready, done, read_data, misaligned
    );
endinterface

// File: rtl/data_memory_unit.sv
// Byte-addressable big-endian data memory with configurable latency, lane-masked stores,
// sign/zero-extending loads and alignment-error reporting.
module data_memory_unit #(
    parameter int unsigned ADDRESS_LENGTH = 8,
    parameter int unsigned LATENCY        = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    data_memory_unit_if.slave bus
);
    localparam int unsigned DEPTH  = 2 ** ADDRESS_LENGTH;
    localparam int unsigned ADDR_W = ADDRESS_LENGTH + 2;
    localparam int unsigned CNT_W  = 4;
    // Counter holds the number of BUSY cycles still to spend, so RESP follows edge E_LATENCY.
    localparam logic [CNT_W-1:0] BUSY_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                accept_c, commit_c;

    logic                we_q, uns_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

    logic                ready_q, done_q, mis_q;
    logic [31:0]         rdata_q;

    logic [31:0]         mem [DEPTH];

    logic                cmd_we_c, cmd_uns_c;
    logic [1:0]          cmd_size_c;
    logic [ADDR_W-1:0]   cmd_addr_c;
    logic [31:0]         cmd_wdata_c;
    logic [1:0]          offset_c;
    logic [ADDRESS_LENGTH-1:0] idx_c;
    logic                err_c;
    logic [31:0]         word_c, wmask_c, wdata_c, load_c;
    logic [4:0]          byte_sh_c, half_sh_c;
    logic [7:0]          sel_byte_c;
    logic [15:0]         sel_half_c;

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_c = 1'b0;
        accept_c = bus.req && ready_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept_c) begin
                    if (LATENCY == 1) begin
                        state_d  = RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = BUSY_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With single-cycle latency the commit edge is the accept edge, so the live inputs are the command.
    always_comb begin
        cmd_we_c    = we_q;
        cmd_uns_c   = uns_q;
        cmd_size_c  = size_q;
        cmd_addr_c  = addr_q;
        cmd_wdata_c = wdata_q;
        if (LATENCY == 1) begin
            cmd_we_c    = bus.write_enable;
            cmd_uns_c   = bus.unsigned_load;
            cmd_size_c  = bus.size;
            cmd_addr_c  = bus.address;
            cmd_wdata_c = bus.write_data;
        end
    end

    // Lane selection, store merge and load extension (offset 0 is the most significant lane)
    always_comb begin
        offset_c   = cmd_addr_c[1:0];
        idx_c      = cmd_addr_c[ADDR_W-1:2];
        err_c      = (cmd_size_c == 2'b11)
                   || (cmd_size_c == 2'b01 && offset_c[0])
                   || (cmd_size_c == 2'b10 && offset_c != 2'b00);
        word_c     = mem[idx_c];
        byte_sh_c  = {~offset_c, 3'b000};
        half_sh_c  = {~offset_c[1], 4'b0000};
        sel_byte_c = 8'(word_c >> byte_sh_c);
        sel_half_c = 16'(word_c >> half_sh_c);
        wmask_c    = 32'hFFFF_FFFF;
        wdata_c    = cmd_wdata_c;
        load_c     = word_c;
        case (cmd_size_c)
            2'b00: begin
                wmask_c = 32'h0000_00FF << byte_sh_c;
                wdata_c = {24'h0, cmd_wdata_c[7:0]} << byte_sh_c;
                load_c  = cmd_uns_c ? {24'h0, sel_byte_c} : {{24{sel_byte_c[7]}}, sel_byte_c};
            end
            2'b01: begin
                wmask_c = 32'h0000_FFFF << half_sh_c;
                wdata_c = {16'h0, cmd_wdata_c[15:0]} << half_sh_c;
                load_c  = cmd_uns_c ? {16'h0, sel_half_c} : {{16{sel_half_c[15]}}, sel_half_c};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d != BUSY);
            done_q  <= commit_c;
            mis_q   <= commit_c && err_c;
            if (accept_c) begin
                we_q    <= bus.write_enable;
                uns_q   <= bus.unsigned_load;
                size_q  <= bus.size;
                addr_q  <= bus.address;
                wdata_q <= bus.write_data;
            end
            if (commit_c && !cmd_we_c && !err_c) begin
                rdata_q <= load_c;
            end
        end
    end

    // Storage array is deliberately not reset
    always_ff @(posedge clk) begin
        if (commit_c && cmd_we_c && !err_c) begin
            mem[idx_c] <= (word_c & ~wmask_c) | (wdata_c & wmask_c);
        end
    end

    assign bus.ready      = ready_q;
    assign bus.done       = done_q;
    assign bus.misaligned = mis_q;
    assign bus.read_data  = rdata_q;
endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: main checks at LATENCY=2, throughput at LATENCY=1 and 4.
module tb_data_memory_unit;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    int          lat;
    logic [31:0] rd;
    logic        mis;

    data_memory_unit_if #(.ADDRESS_LENGTH(8)) m2 ();
    data_memory_unit_if #(.ADDRESS_LENGTH(8)) m1 ();
    data_memory_unit_if #(.ADDRESS_LENGTH(8)) m4 ();

    data_memory_unit #(.ADDRESS_LENGTH(8), .LATENCY(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(m2));
    data_memory_unit #(.ADDRESS_LENGTH(8), .LATENCY(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(m1));
    data_memory_unit #(.ADDRESS_LENGTH(8), .LATENCY(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(m4));

    // Issue one request on the LATENCY=2 unit from a negedge; returns at the negedge of its done cycle.
    task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [9:0] a, input logic [31:0] wd,
                         output int l, output logic [31:0] r, output logic m);
        logic found;
        m2.req = 1'b1; m2.write_enable = we; m2.size = sz; m2.unsigned_load = uns;
        m2.address = a; m2.write_data = wd;
        @(negedge clk);
        m2.req = 1'b0;
        l = -1; r = 32'h0; m = 1'b0; found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!found) begin
                if (m2.done === 1'b1) begin
                    found = 1'b1; l = k; r = m2.read_data; m = m2.misaligned;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (m2.ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", m2.ready); else passes++;
        checks++; if (m2.done !== 1'b0) $display("FAIL reset_done: got %b want 0", m2.done); else passes++;
        checks++; if (m2.misaligned !== 1'b0) $display("FAIL reset_mis: got %b want 0", m2.misaligned); else passes++;
        checks++; if (m2.read_data !== 32'h0) $display("FAIL reset_rdata: got %h want 0", m2.read_data); else passes++;
        checks++; if (m1.ready !== 1'b1 || m4.ready !== 1'b1) $display("FAIL reset_ready_l1l4: got %b%b want 11", m1.ready, m4.ready); else passes++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_access();
        do_op(1'b1, 2'b10, 1'b0, 10'h010, 32'h1122_3344, lat, rd, mis);
        checks++; if (lat != 2) $display("FAIL sw_latency: got %0d want 2", lat); else passes++;
        checks++; if (mis !== 1'b0) $display("FAIL sw_mis: got %b want 0", mis); else passes++;
        do_op(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, rd, mis);
        checks++; if (lat != 2) $display("FAIL lw_latency: got %0d want 2", lat); else passes++;
        checks++; if (rd !== 32'h1122_3344) $display("FAIL lw_data: got %h want 11223344", rd); else passes++;
        checks++; if (mis !== 1'b0) $display("FAIL lw_mis: got %b want 0", mis); else passes++;
    endtask

    task automatic test_byte_lanes();
        do_op(1'b1, 2'b00, 1'b0, 10'h011, 32'h0000_00AA, lat, rd, mis);
        do_op(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, rd, mis);
        checks++; if (rd !== 32'h11AA_3344) $display("FAIL sb_word: got %h want 11aa3344", rd); else passes++;
        do_op(1'b0, 2'b00, 1'b0, 10'h011, 32'h0, lat, rd, mis);
        checks++; if (rd !== 32'hFFFF_FFAA) $display("FAIL lb_signed: got %h want ffffffaa", rd); else passes++;
        do_op(1'b0, 2'b00, 1'b1, 10'h011, 32'h0, lat, rd, mis);
        checks++; if (rd !== 32'h0000_00AA) $display("FAIL lbu: got %h want 000000aa", rd); else passes++;
        do_op(1'b0, 2'b00, 1'b0, 10'h013, 32'h0, lat, rd, mis);
        checks++; if (rd !== 32'h0000_0044) $display("FAIL lb_off3: got %h want 00000044", rd); else passes++;
    endtask

    task automatic test_half_lanes();
        do_op(1'b1, 2'b01, 1'b0, 10'h012, 32'hFFFF_8001, lat, rd, mis);
        do_op(1'b0, 2'b01, 1'b0, 10'h012, 32'h0, lat, rd, mis);
        checks++; if (rd !== 32'hFFFF_8001) $display("FAIL lh_signed: got %h want ffff8001", rd); else passes++;
        do_op(1'b0, 2'b01, 1'b1, 10'h012, 32'h0, lat, rd, mis);
        checks++; if (rd !== 32'h0000_8001) $display("FAIL lhu: got %h want 00008001", rd); else passes++;
        do_op(1'b0, 2'b01, 1'b1, 10'h010, 32'h0, lat, rd, mis);
        checks++; if (rd !== 32'h0000_11AA) $display("FAIL lhu_off0: got %h want 000011aa", rd); else passes++;
        do_op(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, rd, mis);
        checks++; if (rd !== 32'h11AA_8001) $display("FAIL sh_word: got %h want 11aa8001", rd); else passes++;
    endtask

    task automatic test_misaligned();
        do_op(1'b1, 2'b10, 1'b0, 10'h013, 32'hCAFE_BABE, lat, rd, mis);
        checks++; if (mis !== 1'b1) $display("FAIL mis_sw: got %b want 1", mis); else passes++;
        checks++; if (lat != 2) $display("FAIL mis_latency: got %0d want 2", lat); else passes++;
        do_op(1'b0, 2'b01, 1'b0, 10'h011, 32'h0, lat, rd, mis);
        checks++; if (mis !== 1'b1) $display("FAIL mis_lh: got %b want 1", mis); else passes++;
        checks++; if (rd !== 32'h11AA_8001) $display("FAIL mis_rdata_held: got %h want 11aa8001", rd); else passes++;
        do_op(1'b0, 2'b11, 1'b0, 10'h010, 32'h0, lat, rd, mis);
        checks++; if (mis !== 1'b1) $display("FAIL mis_size11: got %b want 1", mis); else passes++;
        do_op(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, rd, mis);
        checks++; if (rd !== 32'h11AA_8001 || mis !== 1'b0) $display("FAIL mis_no_write: got %h/%b want 11aa8001/0", rd, mis); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (m2.done !== 1'b0 || m2.misaligned !== 1'b0) $display("FAIL idle_flags: got %b%b want 00", m2.done, m2.misaligned); else passes++;
        checks++; if (m2.read_data !== 32'h11AA_8001) $display("FAIL rdata_hold: got %h want 11aa8001", m2.read_data); else passes++;
    endtask

    task automatic test_back_to_back();
        int cnt, first, second, last, rlow;
        // LATENCY=2: store then load of the same word with req held; inputs change while busy.
        cnt = 0; first = -1; second = -1; rd = 32'h0;
        m2.req = 1'b1; m2.write_enable = 1'b1; m2.size = 2'b10; m2.unsigned_load = 1'b0;
        m2.address = 10'h030; m2.write_data = 32'h0BAD_F00D;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m2.done === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
                else if (second < 0) begin second = i; rd = m2.read_data; end
            end
            if (i == 0) begin m2.write_enable = 1'b0; m2.write_data = 32'hFFFF_FFFF; end
            if (i == 3) m2.req = 1'b0;
        end
        checks++; if (first != 2 || second != 5) $display("FAIL b2b_l2_timing: got %0d,%0d want 2,5", first, second); else passes++;
        checks++; if (cnt != 2) $display("FAIL b2b_l2_count: got %0d want 2", cnt); else passes++;
        checks++; if (rd !== 32'h0BAD_F00D) $display("FAIL b2b_l2_raw: got %h want 0badf00d", rd); else passes++;

        // LATENCY=1: one accept per cycle, ready never drops
        cnt = 0; rlow = 0; first = -1; rd = 32'h0;
        m1.req = 1'b1; m1.write_enable = 1'b1; m1.size = 2'b10; m1.unsigned_load = 1'b0;
        m1.address = 10'h000; m1.write_data = 32'h5A5A_A5A5;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (m1.done === 1'b1) begin cnt++; if (first < 0) first = i; end
            if (m1.ready !== 1'b1) rlow++;
            if (i == 7) m1.write_enable = 1'b0;
            if (i == 8) begin rd = m1.read_data; m1.req = 1'b0; end
        end
        checks++; if (first != 0) $display("FAIL b2b_l1_first: got %0d want 0", first); else passes++;
        checks++; if (cnt != 9) $display("FAIL b2b_l1_count: got %0d want 9", cnt); else passes++;
        checks++; if (rlow != 0) $display("FAIL b2b_l1_ready: got %0d low cycles want 0", rlow); else passes++;
        checks++; if (rd !== 32'h5A5A_A5A5) $display("FAIL b2b_l1_raw: got %h want 5a5aa5a5", rd); else passes++;

        // LATENCY=4: one accept per 5 cycles; requests while busy add nothing
        cnt = 0; first = -1; last = -1;
        m4.req = 1'b1; m4.write_enable = 1'b1; m4.size = 2'b10; m4.unsigned_load = 1'b0;
        m4.address = 10'h004; m4.write_data = 32'h1357_9BDF;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (m4.done === 1'b1) begin cnt++; if (first < 0) first = i; last = i; end
            if (i == 14) m4.req = 1'b0;
        end
        checks++; if (cnt != 3) $display("FAIL b2b_l4_count: got %0d want 3", cnt); else passes++;
        checks++; if (first != 4 || last != 14) $display("FAIL b2b_l4_timing: got %0d,%0d want 4,14", first, last); else passes++;
    endtask

    task automatic test_reset_in_busy();
        int seen;
        do_op(1'b1, 2'b10, 1'b0, 10'h020, 32'h0, lat, rd, mis);
        m2.req = 1'b1; m2.write_enable = 1'b1; m2.size = 2'b10; m2.address = 10'h020;
        m2.write_data = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        m2.req = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (m2.done !== 1'b0 || m2.ready !== 1'b1) $display("FAIL rst_busy_async: got done=%b ready=%b want 0/1", m2.done, m2.ready); else passes++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (m2.done !== 1'b0) seen++;
        end
        checks++; if (seen != 0) $display("FAIL rst_busy_no_done: got %0d done cycles want 0", seen); else passes++;
        checks++; if (m2.ready !== 1'b1) $display("FAIL rst_busy_ready: got %b want 1", m2.ready); else passes++;
        do_op(1'b0, 2'b10, 1'b0, 10'h020, 32'h0, lat, rd, mis);
        checks++; if (lat != 2 || rd !== 32'h0) $display("FAIL rst_busy_no_write: got lat=%0d data=%h want 2/00000000", lat, rd); else passes++;
    endtask

    initial begin
        m2.req = 1'b0; m2.write_enable = 1'b0; m2.size = 2'b00; m2.unsigned_load = 1'b0;
        m2.address = '0; m2.write_data = '0;
        m1.req = 1'b0; m1.write_enable = 1'b0; m1.size = 2'b00; m1.unsigned_load = 1'b0;
        m1.address = '0; m1.write_data = '0;
        m4.req = 1'b0; m4.write_enable = 1'b0; m4.size = 2'b00; m4.unsigned_load = 1'b0;
        m4.address = '0; m4.write_data = '0;
        test_reset();
        test_word_access();
        test_byte_lanes();
        test_half_lanes();
        test_misaligned();
        test_back_to_back();
        test_reset_in_busy();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
